// File: rtl/ase_sim_local_mem_arb_pkg.sv
// Shared types for the local-memory AVMM arbiter: port-id width helper,
// read-tracking entry and arbiter state encoding.
package ase_sim_local_mem_arb_pkg;

    // Tracking entries are sized for the largest supported configuration.
    localparam int TRK_PORT_W  = 8;
    localparam int TRK_BURST_W = 16;

    function automatic int port_id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    typedef struct packed {
        logic [TRK_PORT_W-1:0]  port;
        logic [TRK_BURST_W-1:0] burstcount;
    } trk_entry_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ase_sim_local_mem_avmm_arbiter_if.sv
// Requester-side and bank-side AVMM signals of the arbiter, bundled.
// Handshake: a command transfers on a cycle where read/write is high and waitrequest is low.
interface ase_sim_local_mem_avmm_arbiter_if #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7
) ();
    localparam int DATA_N_BYTES = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                      s_read;
    logic [NUM_PORTS-1:0]                      s_write;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]      s_address;
    logic [NUM_PORTS-1:0][BURST_CNT_WIDTH-1:0] s_burstcount;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      s_writedata;
    logic [NUM_PORTS-1:0][DATA_N_BYTES-1:0]    s_byteenable;
    logic [NUM_PORTS-1:0]                      s_waitrequest;
    logic [DATA_WIDTH-1:0]                     s_readdata;
    logic [NUM_PORTS-1:0]                      s_readdatavalid;

    logic                       m_read;
    logic                       m_write;
    logic [ADDR_WIDTH-1:0]      m_address;
    logic [BURST_CNT_WIDTH-1:0] m_burstcount;
    logic [DATA_WIDTH-1:0]      m_writedata;
    logic [DATA_N_BYTES-1:0]    m_byteenable;
    logic                       m_waitrequest;
    logic [DATA_WIDTH-1:0]      m_readdata;
    logic                       m_readdatavalid;

    // slave: the arbiter's view; master: the requesters plus bank bridge around it.
    modport slave (
        input  s_read, s_write, s_address, s_burstcount, s_writedata, s_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output s_waitrequest, s_readdata, s_readdatavalid,
        output m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable
    );

    modport master (
        output s_read, s_write, s_address, s_burstcount, s_writedata, s_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        input  m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable
    );
endinterface

// File: rtl/ase_sim_local_mem_arb_fifo.sv
// Synchronous FIFO holding outstanding read bursts, with registered full/empty.
module ase_sim_local_mem_arb_fifo
    import ase_sim_local_mem_arb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  trk_entry_t push_data,
    input  logic       pop,
    output trk_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    trk_entry_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_n;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)
            count_n = count + 1'b1;
        else if (!do_push && do_pop)
            count_n = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end
endmodule

// File: rtl/ase_sim_local_mem_avmm_arbiter.sv
// Round-robin arbiter sharing one local-memory bank between NUM_PORTS AVMM requesters,
// with write-burst locking and read-response routing through a tracking FIFO.
module ase_sim_local_mem_avmm_arbiter
    import ase_sim_local_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RD_TRACK_DEPTH  = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    ase_sim_local_mem_avmm_arbiter_if.slave   bus,
    output logic                              err_orphan_rsp,
    output arb_state_t                        dbg_state
);
    localparam int PW = port_id_width(NUM_PORTS);
    localparam int BW = BURST_CNT_WIDTH;
    localparam int DATA_N_BYTES = DATA_WIDTH / 8;

    arb_state_t            state, state_n;
    logic [PW-1:0]         rr_ptr, rr_ptr_n, wr_port, wr_port_n, gnt, idx, ptr_inc;
    logic [BW-1:0]         wr_left, wr_left_n, rd_left, rd_left_n;
    logic [BW-1:0]         gnt_bc, head_bc, rd_remain;
    logic                  err_n, found, is_wr, is_rd, accept, push, pop;
    logic                  fifo_full, fifo_empty, rd_last, rsp_valid;
    logic [NUM_PORTS-1:0]  req;
    logic [ADDR_WIDTH-1:0]   mux_addr;
    logic [DATA_WIDTH-1:0]   mux_wdata;
    logic [DATA_N_BYTES-1:0] mux_be;
    trk_entry_t            push_entry, head;
    logic                  unused_head_bits;

    // Reads only compete while the tracker has room.
    assign req = bus.s_write | (bus.s_read & ~{NUM_PORTS{fifo_full}});

    always_comb begin
        gnt   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        if (state == ST_WR_BURST) begin
            gnt   = wr_port;
            found = bus.s_write[wr_port];
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
        end
    end

    assign is_wr   = found && bus.s_write[gnt];
    assign is_rd   = found && !bus.s_write[gnt] && bus.s_read[gnt] && !fifo_full
                     && (state == ST_IDLE);
    assign accept  = (is_wr || is_rd) && !bus.m_waitrequest;
    assign gnt_bc  = bus.s_burstcount[gnt];
    assign ptr_inc = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;

    assign mux_addr  = bus.s_address[gnt];
    assign mux_wdata = bus.s_writedata[gnt];
    assign mux_be    = bus.s_byteenable[gnt];

    assign bus.m_read       = is_rd && !reset;
    assign bus.m_write      = is_wr && !reset;
    assign bus.m_address    = mux_addr;
    assign bus.m_burstcount = gnt_bc;
    assign bus.m_writedata  = mux_wdata;
    assign bus.m_byteenable = mux_be;

    always_comb begin
        bus.s_waitrequest = '1;
        if (is_wr || is_rd)
            bus.s_waitrequest[gnt] = bus.m_waitrequest;
    end

    assign push       = accept && is_rd;
    assign push_entry = '{port: TRK_PORT_W'(gnt), burstcount: TRK_BURST_W'(gnt_bc)};

    // rd_left == 0 means the head burst has not delivered any beat yet.
    assign head_bc   = head.burstcount[BW-1:0];
    assign rd_remain = (rd_left == '0) ? head_bc : rd_left;
    assign rd_last   = (rd_remain == BW'(1));
    assign rsp_valid = bus.m_readdatavalid && !fifo_empty && !reset;
    assign pop       = rsp_valid && rd_last;
    assign unused_head_bits = ^{head.port[TRK_PORT_W-1:PW], head.burstcount[TRK_BURST_W-1:BW]};

    assign bus.s_readdata = bus.m_readdata;
    always_comb begin
        bus.s_readdatavalid = '0;
        if (rsp_valid)
            bus.s_readdatavalid[head.port[PW-1:0]] = 1'b1;
    end

    always_comb begin
        state_n   = state;
        wr_port_n = wr_port;
        wr_left_n = wr_left;
        rr_ptr_n  = rr_ptr;
        rd_left_n = rd_left;
        err_n     = err_orphan_rsp;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_wr && gnt_bc > BW'(1)) begin
                        state_n   = ST_WR_BURST;
                        wr_port_n = gnt;
                        wr_left_n = gnt_bc - 1'b1;
                    end else begin
                        rr_ptr_n = ptr_inc;
                    end
                end
            end
            ST_WR_BURST: begin
                if (accept) begin
                    wr_left_n = wr_left - 1'b1;
                    if (wr_left == BW'(1)) begin
                        state_n  = ST_IDLE;
                        rr_ptr_n = ptr_inc;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (rsp_valid)
            rd_left_n = rd_last ? '0 : rd_remain - 1'b1;
        if (bus.m_readdatavalid && fifo_empty)
            err_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            wr_port        <= '0;
            wr_left        <= '0;
            rd_left        <= '0;
            err_orphan_rsp <= 1'b0;
        end else begin
            state          <= state_n;
            rr_ptr         <= rr_ptr_n;
            wr_port        <= wr_port_n;
            wr_left        <= wr_left_n;
            rd_left        <= rd_left_n;
            err_orphan_rsp <= err_n;
        end
    end

    assign dbg_state = state;

    ase_sim_local_mem_arb_fifo #(.DEPTH(RD_TRACK_DEPTH)) u_trk_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_zero_burst: assert property (@(posedge clk) disable iff (reset)
        (accept && state == ST_IDLE) |-> (gnt_bc != '0));
endmodule

// File: tb/tb_ase_sim_local_mem_avmm_arbiter.sv
// Directed bench for the local-memory arbiter: arbitration order, burst locking,
// response routing, tracker full, orphan responses and reset mid-burst.
module tb_ase_sim_local_mem_avmm_arbiter;
    import ase_sim_local_mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       err_orphan_rsp;
    arb_state_t dbg_state;
    int         checks = 0;
    int         errors = 0;

    ase_sim_local_mem_avmm_arbiter_if bus ();

    ase_sim_local_mem_avmm_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .err_orphan_rsp (err_orphan_rsp),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.s_read          = '0;
        bus.s_write         = '0;
        bus.s_address       = '0;
        bus.s_burstcount[0] = 7'd1;
        bus.s_burstcount[1] = 7'd1;
        bus.s_writedata     = '0;
        bus.s_byteenable    = '1;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.s_read = 2'b11;
        bus.m_readdatavalid = 1'b1;
        #1;
        checks++; if (bus.m_read !== 1'b0) begin errors++; $display("FAIL reset_m_read: got %b exp 0", bus.m_read); end
        checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL reset_m_write: got %b exp 0", bus.m_write); end
        checks++; if (bus.s_readdatavalid !== 2'b00) begin errors++; $display("FAIL reset_rdv: got %b exp 00", bus.s_readdatavalid); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
        checks++; if (err_orphan_rsp !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_orphan_rsp); end
        checks++; if (bus.s_waitrequest !== 2'b11) begin errors++; $display("FAIL reset_waitreq: got %b exp 11", bus.s_waitrequest); end
    endtask

    task automatic test_rr_reads();
        idle_inputs();
        bus.s_address[0] = 27'h100;
        bus.s_address[1] = 27'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.s_read = 2'b11;
            #1;
            checks++; if (bus.m_read !== 1'b1) begin errors++; $display("FAIL rr_m_read[%0d]: got %b exp 1", i, bus.m_read); end
            checks++; if (bus.m_address !== ((i % 2 == 1) ? 27'h200 : 27'h100)) begin errors++; $display("FAIL rr_addr[%0d]: got %h", i, bus.m_address); end
            checks++; if (bus.s_waitrequest !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_waitreq[%0d]: got %b", i, bus.s_waitrequest); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.s_read = '0;
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = 512'(32'hA0 + i);
            #1;
            checks++; if (bus.s_readdatavalid !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rdv[%0d]: got %b", i, bus.s_readdatavalid); end
            checks++; if (bus.s_readdata !== 512'(32'hA0 + i)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h", i, bus.s_readdata[31:0]); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write_burst();
        logic wait_tbl [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int   beat = 0;
        idle_inputs();
        bus.s_address[0] = 27'h40;
        bus.s_address[1] = 27'h300;
        bus.s_burstcount[0] = 7'd4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.s_write[0] = 1'b1;
            bus.s_read[1] = 1'b1;
            bus.s_writedata[0] = 512'(beat + 1);
            bus.m_waitrequest = wait_tbl[c];
            #1;
            checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin errors++; $display("FAIL wb_cmd[%0d]: got w=%b r=%b exp w=1 r=0", c, bus.m_write, bus.m_read); end
            checks++; if (bus.s_waitrequest !== (wait_tbl[c] ? 2'b11 : 2'b10)) begin errors++; $display("FAIL wb_waitreq[%0d]: got %b", c, bus.s_waitrequest); end
            checks++; if (bus.m_writedata !== 512'(beat + 1)) begin errors++; $display("FAIL wb_wdata[%0d]: got %h exp %0d", c, bus.m_writedata[31:0], beat + 1); end
            checks++; if (dbg_state !== ((c == 0) ? ST_IDLE : ST_WR_BURST)) begin errors++; $display("FAIL wb_state[%0d]: got %0d", c, dbg_state); end
            if (!wait_tbl[c]) beat++;
        end
        @(negedge clk);
        bus.m_waitrequest = 1'b0;
        bus.s_burstcount[0] = 7'd1;
        #1;
        checks++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin errors++; $display("FAIL wb_release: got r=%b w=%b exp r=1 w=0", bus.m_read, bus.m_write); end
        checks++; if (bus.s_waitrequest !== 2'b01) begin errors++; $display("FAIL wb_release_waitreq: got %b exp 01", bus.s_waitrequest); end
        checks++; if (bus.m_address !== 27'h300) begin errors++; $display("FAIL wb_release_addr: got %h exp 300", bus.m_address); end
        @(negedge clk);
        idle_inputs();
        bus.m_readdatavalid = 1'b1;
        #1;
        checks++; if (bus.s_readdatavalid !== 2'b10) begin errors++; $display("FAIL wb_rdv: got %b exp 10", bus.s_readdatavalid); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_routing();
        logic [1:0] exp_rdv [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        idle_inputs();
        @(negedge clk);
        bus.s_read[1] = 1'b1;
        bus.s_burstcount[1] = 7'd3;
        #1;
        checks++; if (bus.m_read !== 1'b1 || bus.m_burstcount !== 7'd3) begin errors++; $display("FAIL rt_cmd1: got r=%b bc=%0d exp r=1 bc=3", bus.m_read, bus.m_burstcount); end
        checks++; if (bus.s_waitrequest !== 2'b01) begin errors++; $display("FAIL rt_waitreq1: got %b exp 01", bus.s_waitrequest); end
        @(negedge clk);
        bus.s_read = 2'b01;
        bus.s_burstcount[0] = 7'd2;
        #1;
        checks++; if (bus.m_read !== 1'b1 || bus.m_burstcount !== 7'd2) begin errors++; $display("FAIL rt_cmd0: got r=%b bc=%0d exp r=1 bc=2", bus.m_read, bus.m_burstcount); end
        checks++; if (bus.s_waitrequest !== 2'b10) begin errors++; $display("FAIL rt_waitreq0: got %b exp 10", bus.s_waitrequest); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.s_read = '0;
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = 512'(32'hC0 + i);
            #1;
            checks++; if (bus.s_readdatavalid !== exp_rdv[i]) begin errors++; $display("FAIL rt_rdv[%0d]: got %b exp %b", i, bus.s_readdatavalid, exp_rdv[i]); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        idle_inputs();
        bus.s_address[1] = 27'h500;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.s_read[0] = 1'b1;
            #1;
            checks++; if (bus.m_read !== 1'b1 || bus.s_waitrequest[0] !== 1'b0) begin errors++; $display("FAIL ff_fill[%0d]: got r=%b wr0=%b exp r=1 wr0=0", i, bus.m_read, bus.s_waitrequest[0]); end
        end
        @(negedge clk);
        bus.s_write[1] = 1'b1;
        #1;
        checks++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b1) begin errors++; $display("FAIL ff_full_cmd: got r=%b w=%b exp r=0 w=1", bus.m_read, bus.m_write); end
        checks++; if (bus.s_waitrequest !== 2'b01) begin errors++; $display("FAIL ff_full_waitreq: got %b exp 01", bus.s_waitrequest); end
        @(negedge clk);
        bus.s_write[1] = 1'b0;
        bus.m_readdatavalid = 1'b1;
        #1;
        checks++; if (bus.m_read !== 1'b0 || bus.s_waitrequest !== 2'b11) begin errors++; $display("FAIL ff_pop_cycle: got r=%b wr=%b exp r=0 wr=11", bus.m_read, bus.s_waitrequest); end
        checks++; if (bus.s_readdatavalid !== 2'b01) begin errors++; $display("FAIL ff_pop_rdv: got %b exp 01", bus.s_readdatavalid); end
        @(negedge clk);
        bus.m_readdatavalid = 1'b0;
        #1;
        checks++; if (bus.m_read !== 1'b1 || bus.s_waitrequest !== 2'b10) begin errors++; $display("FAIL ff_slot_freed: got r=%b wr=%b exp r=1 wr=10", bus.m_read, bus.s_waitrequest); end
        @(negedge clk);
        #1;
        checks++; if (bus.m_read !== 1'b0) begin errors++; $display("FAIL ff_full_again: got r=%b exp 0", bus.m_read); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.s_read = '0;
            bus.m_readdatavalid = 1'b1;
            #1;
            checks++; if (bus.s_readdatavalid !== 2'b01) begin errors++; $display("FAIL ff_drain[%0d]: got %b exp 01", i, bus.s_readdatavalid); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_orphan();
        idle_inputs();
        @(negedge clk);
        bus.m_readdatavalid = 1'b1;
        #1;
        checks++; if (bus.s_readdatavalid !== 2'b00) begin errors++; $display("FAIL orphan_dropped: got %b exp 00", bus.s_readdatavalid); end
        checks++; if (err_orphan_rsp !== 1'b0) begin errors++; $display("FAIL orphan_err_before: got %b exp 0", err_orphan_rsp); end
        @(negedge clk);
        bus.m_readdatavalid = 1'b0;
        #1;
        checks++; if (err_orphan_rsp !== 1'b1) begin errors++; $display("FAIL orphan_err_set: got %b exp 1", err_orphan_rsp); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_orphan_rsp !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky: got %b exp 1", err_orphan_rsp); end
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        @(negedge clk);
        bus.s_read[1] = 1'b1;
        bus.s_burstcount[1] = 7'd2;
        #1;
        checks++; if (bus.m_read !== 1'b1 || bus.s_waitrequest !== 2'b01) begin errors++; $display("FAIL rmb_read: got r=%b wr=%b exp r=1 wr=01", bus.m_read, bus.s_waitrequest); end
        @(negedge clk);
        bus.s_read = '0;
        bus.s_write[0] = 1'b1;
        bus.s_burstcount[0] = 7'd4;
        bus.s_burstcount[1] = 7'd1;
        #1;
        checks++; if (bus.m_write !== 1'b1 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmb_beat1: got w=%b st=%0d exp w=1 st=0", bus.m_write, dbg_state); end
        @(negedge clk);
        #1;
        checks++; if (bus.m_write !== 1'b1 || dbg_state !== ST_WR_BURST) begin errors++; $display("FAIL rmb_beat2: got w=%b st=%0d exp w=1 st=1", bus.m_write, dbg_state); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL rmb_reset_mwrite: got %b exp 0", bus.m_write); end
        @(negedge clk);
        reset = 1'b0;
        bus.s_write = 2'b10;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmb_state: got %0d exp 0", dbg_state); end
        checks++; if (bus.m_write !== 1'b1 || bus.s_waitrequest !== 2'b01) begin errors++; $display("FAIL rmb_port1_grant: got w=%b wr=%b exp w=1 wr=01", bus.m_write, bus.s_waitrequest); end
        @(negedge clk);
        bus.s_write = '0;
        bus.m_readdatavalid = 1'b1;
        #1;
        checks++; if (bus.s_readdatavalid !== 2'b00) begin errors++; $display("FAIL rmb_fifo_empty: got %b exp 00", bus.s_readdatavalid); end
        @(negedge clk);
        bus.m_readdatavalid = 1'b0;
        #1;
        checks++; if (err_orphan_rsp !== 1'b1) begin errors++; $display("FAIL rmb_orphan: got %b exp 1", err_orphan_rsp); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_rr_reads();
        test_write_burst();
        test_read_routing();
        test_fifo_full();
        test_orphan();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
